decade_counter_driver: RTL and testbench

//  Command-driven stimulus master for the decade counter interface (driver side of counter_ifc).

---
 rtl/decade_drv_pkg.sv | 50 +++++
 rtl/decade_cmd_fifo.sv | 87 ++++++++
 rtl/decade_counter_driver.sv | 277 +++++++++++++++++++++++++++
 tb/tb_decade_counter_driver.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/decade_drv_pkg.sv
// -----------------------------------------------------------------------------
// decade_drv_pkg
//
// Purpose:
//   Shared types and helpers for the decade counter driver: command opcodes,
//   FSM state encoding, the queued command record and the decade increment
//   rule used by the reference model.
//
// Contents:
//   LEN_W        width of the HOLD/COUNT cycle count carried in each command.
//                It lives here because the command record is a packed struct
//                and must have a fixed layout; change it here to resize.
//   cmd_op_e     00 HOLD, 01 COUNT, 10 LOAD, 11 CLEAR
//   state_e      IDLE, LOAD, CLEAR, RUN
//   cmd_t        {op, data, len}
//   next_decade  next counter value under Enable
// -----------------------------------------------------------------------------
package decade_drv_pkg;

    localparam int LEN_W = 8;

    typedef enum logic [1:0] {
        OP_HOLD  = 2'b00,
        OP_COUNT = 2'b01,
        OP_LOAD  = 2'b10,
        OP_CLEAR = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CLEAR = 2'd2,
        ST_RUN   = 2'd3
    } state_e;

    typedef struct packed {
        cmd_op_e          op;
        logic [3:0]       data;
        logic [LEN_W-1:0] len;
    } cmd_t;

    // The counter increments with a 5-bit adder and wraps modulo 10, so an
    // out-of-range loaded value steps to a legal one: 9->0, 10->1, 15->6.
    function automatic logic [3:0] next_decade(input logic [3:0] q);
        logic [4:0] sum;
        sum = ({1'b0, q} + 5'd1) % 5'd10;
        return sum[3:0];
    endfunction

endpackage

// File: rtl/decade_cmd_fifo.sv
// -----------------------------------------------------------------------------
// decade_cmd_fifo
//
// Purpose:
//   Small synchronous FIFO holding queued driver commands (cmd_t). First-word
//   fall-through: pop_data always shows the head entry while not empty.
//
// Parameters:
//   DEPTH      number of entries, power of two and at least 2
//
// Ports:
//   clk        clock, all state on posedge
//   rst_n      asynchronous active-low reset; empties the FIFO
//   push       write push_data (ignored when full)
//   push_data  command to enqueue
//   pop        drop the head entry (ignored when empty)
//   pop_data   head entry
//   full       no free entry
//   empty      no valid entry
// -----------------------------------------------------------------------------
module decade_cmd_fifo
    import decade_drv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  cmd_t push_data,
    input  logic pop,
    output cmd_t pop_data,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    cmd_t        mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push;
    logic        do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // when the index bits are equal.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    // NOTE: every signal written in an always_comb gets a default assignment
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers alone
    // define which entries are valid, and a reset-free array maps onto plain
    // register-file or RAM cells.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/decade_counter_driver.sv
// -----------------------------------------------------------------------------
// decade_counter_driver
//
// Purpose:
//   Command-driven stimulus master for a decade counter. Commands (HOLD, COUNT,
//   LOAD, CLEAR) are queued over a valid/ready handshake and replayed as
//   registered MR/Load/P/Enable drive. An internal reference model tracks what
//   the counter should hold and is compared against the returned Q every cycle.
//
// Parameters:
//   CMD_DEPTH   command FIFO entries (power of two, >= 2)
//   ERR_W       width of the saturating mismatch counter (and wrap counter)
//   (The HOLD/COUNT length width is LEN_W from decade_drv_pkg.)
//
// Ports:
//   CLK         clock, all state on posedge
//   MR_n        asynchronous active-low reset
//   cmd_valid   command offered
//   cmd_ready   FIFO has room; low while in reset
//   cmd_op      00 HOLD, 01 COUNT, 10 LOAD, 11 CLEAR
//   cmd_data    LOAD value
//   cmd_len     HOLD/COUNT cycle count
//   ctr_mr      counter master reset, active high, registered
//   ctr_load    counter Load, registered
//   ctr_p       counter parallel data, registered
//   ctr_enable  counter Enable, registered
//   ctr_q       counter output returned for comparison
//   busy        a command is executing or queued
//   cmd_done    one-cycle pulse when a command's last drive cycle retires
//   exp_q       reference-model value
//   mismatch    sticky compare-failure flag
//   err_cnt     saturating compare-failure count
//   wrap_cnt    saturating count of model 9->0 wraps under Enable
//               (only with DECADE_DRV_WRAP_CNT_EN defined)
//
// Configuration:
//   DECADE_DRV_WRAP_CNT_EN  adds the wrap_cnt output and its counter.
// -----------------------------------------------------------------------------
module decade_counter_driver
    import decade_drv_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int ERR_W     = 8
) (
    input  logic             CLK,
    input  logic             MR_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [3:0]       cmd_data,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             ctr_mr,
    output logic             ctr_load,
    output logic [3:0]       ctr_p,
    output logic             ctr_enable,
    input  logic [3:0]       ctr_q,
    output logic             busy,
    output logic             cmd_done,
    output logic [3:0]       exp_q,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_cnt
`ifdef DECADE_DRV_WRAP_CNT_EN
    ,
    output logic [ERR_W-1:0] wrap_cnt
`endif
);

    // ------------------------------------------------------------------
    // Command queue
    // ------------------------------------------------------------------
    cmd_t fifo_in;
    cmd_t head;
    logic fifo_push;
    logic fifo_pop;
    logic fifo_full;
    logic fifo_empty;
    logic ready_q;

    assign fifo_in   = '{op: cmd_op_e'(cmd_op), data: cmd_data, len: cmd_len};
    // ready_q keeps cmd_ready low during reset and rises one edge after release.
    assign cmd_ready = ready_q && !fifo_full;
    assign fifo_push = cmd_valid && cmd_ready;

    decade_cmd_fifo #(
        .DEPTH(CMD_DEPTH)
    ) u_fifo (
        .clk      (CLK),
        .rst_n    (MR_n),
        .push     (fifo_push),
        .push_data(fifo_in),
        .pop      (fifo_pop),
        .pop_data (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // ------------------------------------------------------------------
    // Sequencer FSM and registered counter drive
    // ------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             ctr_mr_q, ctr_mr_d;
    logic             ctr_load_q, ctr_load_d;
    logic [3:0]       ctr_p_q, ctr_p_d;
    logic             ctr_enable_q, ctr_enable_d;
    logic             cmd_done_q, cmd_done_d;
    logic             last_cycle;

    // rem_q counts RUN cycles still to come after the current one. Any cycle
    // that is not mid-RUN may hand over to the next queued command, which is
    // what removes idle gaps between back-to-back commands.
    assign last_cycle = (state_q != ST_RUN) || (rem_q == '0);

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        ctr_mr_d     = ctr_mr_q;
        ctr_load_d   = ctr_load_q;
        ctr_p_d      = ctr_p_q;
        ctr_enable_d = ctr_enable_q;
        cmd_done_d   = 1'b0;
        fifo_pop     = 1'b0;

        if (!last_cycle) begin
            // Mid-RUN: hold the drive, count down, flag the final cycle.
            rem_d      = rem_q - LEN_W'(1);
            cmd_done_d = (rem_q == LEN_W'(1));
        end else begin
            state_d      = ST_IDLE;
            rem_d        = '0;
            ctr_mr_d     = 1'b0;
            ctr_load_d   = 1'b0;
            ctr_p_d      = 4'd0;
            ctr_enable_d = 1'b0;
            if (!fifo_empty) begin
                fifo_pop = 1'b1;
                case (head.op)
                    OP_LOAD: begin
                        state_d    = ST_LOAD;
                        ctr_load_d = 1'b1;
                        ctr_p_d    = head.data;
                        cmd_done_d = 1'b1;
                    end
                    OP_CLEAR: begin
                        state_d    = ST_CLEAR;
                        ctr_mr_d   = 1'b1;
                        cmd_done_d = 1'b1;
                    end
                    OP_HOLD, OP_COUNT: begin
                        if (head.len == '0) begin
                            // Zero-length: retire with no drive cycles.
                            cmd_done_d = 1'b1;
                        end else begin
                            state_d      = ST_RUN;
                            rem_d        = head.len - LEN_W'(1);
                            ctr_enable_d = (head.op == OP_COUNT);
                            cmd_done_d   = (head.len == LEN_W'(1));
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge CLK or negedge MR_n) begin
        if (!MR_n) begin
            ready_q      <= 1'b0;
            state_q      <= ST_IDLE;
            rem_q        <= '0;
            ctr_mr_q     <= 1'b0;
            ctr_load_q   <= 1'b0;
            ctr_p_q      <= 4'd0;
            ctr_enable_q <= 1'b0;
            cmd_done_q   <= 1'b0;
        end else begin
            ready_q      <= 1'b1;
            state_q      <= state_d;
            rem_q        <= rem_d;
            ctr_mr_q     <= ctr_mr_d;
            ctr_load_q   <= ctr_load_d;
            ctr_p_q      <= ctr_p_d;
            ctr_enable_q <= ctr_enable_d;
            cmd_done_q   <= cmd_done_d;
        end
    end

    assign ctr_mr     = ctr_mr_q;
    assign ctr_load   = ctr_load_q;
    assign ctr_p      = ctr_p_q;
    assign ctr_enable = ctr_enable_q;
    assign cmd_done   = cmd_done_q;
    assign busy       = (state_q != ST_IDLE) || !fifo_empty;

    // ------------------------------------------------------------------
    // Reference model and Q comparison
    // ------------------------------------------------------------------
    logic [3:0]       model_q, model_d;
    logic             mr_prev_q;
    logic             mismatch_q, mismatch_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic             cmp_mask;

    // The counter clears asynchronously as soon as ctr_mr rises, while the
    // model only clears at the edge that ends the MR cycle; the compare is
    // skipped for that edge and the one after it to absorb the skew.
    assign cmp_mask = ctr_mr_q || mr_prev_q;

    always_comb begin
        model_d    = model_q;
        mismatch_d = mismatch_q;
        err_cnt_d  = err_cnt_q;

        if (ctr_mr_q) begin
            model_d = 4'd0;
        end else if (ctr_load_q) begin
            model_d = ctr_p_q;
        end else if (ctr_enable_q) begin
            model_d = next_decade(model_q);
        end

        if (!cmp_mask && (ctr_q != model_q)) begin
            mismatch_d = 1'b1;
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + ERR_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge MR_n) begin
        if (!MR_n) begin
            model_q    <= 4'd0;
            mr_prev_q  <= 1'b0;
            mismatch_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            model_q    <= model_d;
            mr_prev_q  <= ctr_mr_q;
            mismatch_q <= mismatch_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign exp_q    = model_q;
    assign mismatch = mismatch_q;
    assign err_cnt  = err_cnt_q;

`ifdef DECADE_DRV_WRAP_CNT_EN
    // ------------------------------------------------------------------
    // Wrap counter: model steps 9->0 on the Enable path only
    // ------------------------------------------------------------------
    logic [ERR_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic             wrap_tick;

    assign wrap_tick = !ctr_mr_q && !ctr_load_q && ctr_enable_q &&
                       (model_q == 4'd9);

    always_comb begin
        wrap_cnt_d = wrap_cnt_q;
        if (wrap_tick && (wrap_cnt_q != '1)) begin
            wrap_cnt_d = wrap_cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge MR_n) begin
        if (!MR_n) begin
            wrap_cnt_q <= '0;
        end else begin
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    assign wrap_cnt = wrap_cnt_q;
`else
    // Wrap counting is not built in this configuration.
`endif

endmodule

// File: tb/tb_decade_counter_driver.sv
// -----------------------------------------------------------------------------
// tb_decade_counter_driver
//
// Self-checking bench for decade_counter_driver. A behavioural decade counter
// closes the loop on ctr_* / ctr_q; a table of single commands with
// hand-computed model values is replayed, followed by directed sequences for
// reset mid-command, FIFO full/ordering, CLEAR masking, a stuck Q and (when
// built with DECADE_DRV_WRAP_CNT_EN) wrap counting.
// -----------------------------------------------------------------------------
module tb_decade_counter_driver;
    import decade_drv_pkg::*;

    logic       CLK = 1'b0;
    logic       MR_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;
    logic [7:0] cmd_len;
    logic       ctr_mr, ctr_load, ctr_enable;
    logic [3:0] ctr_p, ctr_q;
    logic       busy, cmd_done, mismatch;
    logic [3:0] exp_q;
    logic [7:0] err_cnt;
`ifdef DECADE_DRV_WRAP_CNT_EN
    logic [7:0] wrap_cnt;
`endif

    always #5 CLK = ~CLK;

    decade_counter_driver #(
        .CMD_DEPTH(4),
        .ERR_W    (8)
    ) dut (
        .CLK       (CLK),
        .MR_n      (MR_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_len   (cmd_len),
        .ctr_mr    (ctr_mr),
        .ctr_load  (ctr_load),
        .ctr_p     (ctr_p),
        .ctr_enable(ctr_enable),
        .ctr_q     (ctr_q),
        .busy      (busy),
        .cmd_done  (cmd_done),
        .exp_q     (exp_q),
        .mismatch  (mismatch),
        .err_cnt   (err_cnt)
`ifdef DECADE_DRV_WRAP_CNT_EN
        ,
        .wrap_cnt  (wrap_cnt)
`endif
    );

    // Behavioural counter: async clear from ctr_mr, 9..15 step to value-9.
    logic [3:0] cnt_q;
    logic       stuck;
    always @(posedge CLK or negedge MR_n) begin
        if (!MR_n)           cnt_q <= 4'd0;
        else if (ctr_mr)     cnt_q <= 4'd0;
        else if (ctr_load)   cnt_q <= ctr_p;
        else if (ctr_enable) cnt_q <= (cnt_q >= 4'd9) ? cnt_q - 4'd9 : cnt_q + 4'd1;
    end
    assign ctr_q = stuck ? 4'd3 : (ctr_mr ? 4'd0 : cnt_q);

    // Monitor: running totals sampled mid-cycle.
    int         cyc = 0;
    int         n_en = 0, n_load = 0, n_mr = 0, n_done = 0;
    logic [3:0] load_p_log[$];
    int         load_cyc_log[$];
    always @(negedge CLK) begin
        cyc++;
        if (MR_n) begin
            if (ctr_enable) n_en++;
            if (ctr_mr)     n_mr++;
            if (cmd_done)   n_done++;
            if (ctr_load) begin
                n_load++;
                load_p_log.push_back(ctr_p);
                load_cyc_log.push_back(cyc);
            end
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    task automatic push_cmd(input cmd_op_e op, input logic [3:0] data, input logic [7:0] len);
        int k;
        k = 0;
        @(negedge CLK);
        while (!cmd_ready && k < 200) begin
            @(negedge CLK);
            k++;
        end
        check("push_ready_timeout", int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_len   = len;
        @(posedge CLK);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        @(negedge CLK);
        while (busy && k < 400) begin
            @(negedge CLK);
            k++;
        end
        check(name, int'(busy), 0);
        @(negedge CLK);
    endtask

    typedef struct {
        cmd_op_e    op;
        logic [3:0] data;
        logic [7:0] len;
        logic [3:0] exp;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs[NV];

    initial begin
        int b_en, b_load, b_mr, b_done, n;
        string nm;

        // {op, data, len, expected model value after the command}
        vecs[0]  = '{OP_LOAD,  4'd7,  8'd0, 4'd7};
        vecs[1]  = '{OP_COUNT, 4'd0,  8'd5, 4'd2};   // 8,9,0,1,2
        vecs[2]  = '{OP_LOAD,  4'd15, 8'd0, 4'd15};
        vecs[3]  = '{OP_COUNT, 4'd0,  8'd1, 4'd6};   // 15 -> 6
        vecs[4]  = '{OP_COUNT, 4'd0,  8'd1, 4'd7};
        vecs[5]  = '{OP_HOLD,  4'd0,  8'd3, 4'd7};
        vecs[6]  = '{OP_COUNT, 4'd0,  8'd0, 4'd7};   // zero length
        vecs[7]  = '{OP_LOAD,  4'd9,  8'd0, 4'd9};
        vecs[8]  = '{OP_COUNT, 4'd0,  8'd1, 4'd0};   // 9 -> 0
        vecs[9]  = '{OP_LOAD,  4'd10, 8'd0, 4'd10};
        vecs[10] = '{OP_COUNT, 4'd0,  8'd1, 4'd1};   // 10 -> 1
        vecs[11] = '{OP_CLEAR, 4'd0,  8'd0, 4'd0};
        vecs[12] = '{OP_COUNT, 4'd0,  8'd4, 4'd4};
        vecs[13] = '{OP_CLEAR, 4'd0,  8'd0, 4'd0};   // clear after count to 4
        vecs[14] = '{OP_HOLD,  4'd0,  8'd0, 4'd0};
        vecs[15] = '{OP_COUNT, 4'd0,  8'd12, 4'd2};

        MR_n = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 4'd0;
        cmd_len = 8'd0; stuck = 1'b0;
        #2 MR_n = 1'b0;
        #10;
        check("rst_ready",    int'(cmd_ready),  0);
        check("rst_busy",     int'(busy),       0);
        check("rst_exp_q",    int'(exp_q),      0);
        check("rst_enable",   int'(ctr_enable), 0);
        check("rst_err_cnt",  int'(err_cnt),    0);
        @(negedge CLK) MR_n = 1'b1;
        @(negedge CLK);
        check("ready_after_release", int'(cmd_ready), 1);

        // ---- reset in the middle of a RUN with a command queued ----
        push_cmd(OP_COUNT, 4'd0, 8'd20);
        push_cmd(OP_LOAD,  4'd5, 8'd0);
        repeat (5) @(negedge CLK);
        check("midrun_enable", int'(ctr_enable), 1);
        b_done = n_done; b_load = n_load;
        #2 MR_n = 1'b0;
        #1;
        check("midrst_enable", int'(ctr_enable), 0);
        check("midrst_busy",   int'(busy),       0);
        check("midrst_ready",  int'(cmd_ready),  0);
        check("midrst_exp_q",  int'(exp_q),      0);
        check("midrst_done",   int'(cmd_done),   0);
        repeat (2) @(negedge CLK);
        MR_n = 1'b1;
        repeat (10) @(negedge CLK);
        check("postrst_no_done", n_done - b_done, 0);
        check("postrst_no_load", n_load - b_load, 0);
        check("postrst_busy",    int'(busy),      0);

        // ---- table of single commands ----
        for (int i = 0; i < NV; i++) begin
            b_en = n_en; b_load = n_load; b_mr = n_mr; b_done = n_done;
            push_cmd(vecs[i].op, vecs[i].data, vecs[i].len);
            nm = $sformatf("v%0d_", i);
            wait_idle({nm, "idle"});
            check({nm, "exp_q"},    int'(exp_q), int'(vecs[i].exp));
            check({nm, "ctr_q"},    int'(ctr_q), int'(vecs[i].exp));
            check({nm, "en_cyc"},   n_en - b_en, (vecs[i].op == OP_COUNT) ? int'(vecs[i].len) : 0);
            check({nm, "load_cyc"}, n_load - b_load, (vecs[i].op == OP_LOAD) ? 1 : 0);
            check({nm, "mr_cyc"},   n_mr - b_mr, (vecs[i].op == OP_CLEAR) ? 1 : 0);
            check({nm, "done"},     n_done - b_done, 1);
            check({nm, "mismatch"}, int'(mismatch), 0);
            if (vecs[i].op == OP_LOAD)
                check({nm, "ctr_p"}, int'(load_p_log[load_p_log.size()-1]), int'(vecs[i].data));
        end

`ifdef DECADE_DRV_WRAP_CNT_EN
        // ---- wrap counting: LOAD 8, COUNT 12 -> two 9->0 wraps ----
        n = int'(wrap_cnt);
        push_cmd(OP_LOAD,  4'd8, 8'd0);
        push_cmd(OP_COUNT, 4'd0, 8'd12);
        wait_idle("wrap_idle");
        check("wrap_cnt_delta", int'(wrap_cnt) - n, 2);
        check("wrap_exp_q",     int'(exp_q), 0);
`endif

        // ---- FIFO full while stalled behind a long HOLD, order kept ----
        push_cmd(OP_HOLD, 4'd0, 8'd30);
        repeat (2) @(negedge CLK);
        for (int k = 1; k <= 4; k++) push_cmd(OP_LOAD, 4'(k), 8'd0);
        @(negedge CLK);
        check("full_ready_low", int'(cmd_ready), 0);
        check("full_busy",      int'(busy),      1);
        push_cmd(OP_LOAD, 4'd5, 8'd0);
        wait_idle("full_idle");
        n = load_p_log.size();
        for (int k = 0; k < 5; k++)
            check($sformatf("order_p%0d", k), int'(load_p_log[n-5+k]), k + 1);
        check("loads_back_to_back", load_cyc_log[n-1] - load_cyc_log[n-5], 4);
        check("full_exp_q",    int'(exp_q),    5);
        check("full_mismatch", int'(mismatch), 0);

        // ---- stuck Q during COUNT 4 from 3 -> three failures ----
        push_cmd(OP_LOAD, 4'd3, 8'd0);
        wait_idle("stuck_load_idle");
        stuck = 1'b1;
        push_cmd(OP_COUNT, 4'd0, 8'd4);
        n = 0;
        @(negedge CLK);
        while (!cmd_done && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check("stuck_done_seen", int'(cmd_done), 1);
        @(posedge CLK);
        #1 stuck = 1'b0;
        wait_idle("stuck_idle");
        check("stuck_mismatch", int'(mismatch), 1);
        check("stuck_err_cnt",  int'(err_cnt),  3);
        check("stuck_exp_q",    int'(exp_q),    7);
        repeat (3) @(negedge CLK);
        check("stuck_err_hold", int'(err_cnt),  3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
